// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: fetch FSM encodings and opcode constants shared by fetch, decode and branch control
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
  localparam logic [4:0] OP_JR   = 5'b01101;
  localparam logic [4:0] OP_JPC  = 5'b01110;
  localparam logic [4:0] OP_BRFL = 5'b01111;
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET  = 5'b10001;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: single-outstanding request/response bus to the instruction memory
interface instr_fetch_unit_if #(parameter int AWIDTH = 15, DWIDTH = 32);
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_valid;
  logic [DWIDTH-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one word at a time into a registered decode slot with a one-entry skid,
// and redirects to r_abs when decode consumes a taken branch, discarding stale memory responses.
module instr_fetch_unit import instr_fetch_unit_pkg::*; #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 15,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DWIDTH-1:0] r_abs,
  instr_fetch_unit_if.master imem,
  output logic [DWIDTH-1:0] instr,
  output logic              instr_valid,
  output logic [AWIDTH-1:0] instr_pc,
  output logic [AWIDTH-1:0] ret_addr
);
  fetch_state_t state, state_n;
  logic [AWIDTH-1:0] pc, pc_n, pc_inc, target;
  logic [DWIDTH-1:0] skid, skid_n, load_data;
  logic discard, discard_n, consume, redirect, load;
  logic unused_hi;
  assign consume   = instr_valid & ~stall;
  assign redirect  = consume & branch_taken;
  assign pc_inc    = pc + AWIDTH'(1);
  assign target    = r_abs[AWIDTH-1:0];
  assign unused_hi = ^r_abs[DWIDTH-1:AWIDTH];
  assign load_data = (state == HOLD) ? skid : imem.imem_rdata;
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    skid_n    = skid;
    load      = 1'b0;
    case (state)
      REQ: begin
        state_n   = (redirect | imem.imem_req) ? WAIT : REQ;
        discard_n = discard | redirect;
        pc_n      = redirect ? target : pc;
      end
      WAIT: begin
        if (redirect) begin
          pc_n      = target;
          state_n   = imem.imem_valid ? REQ : WAIT;
          discard_n = ~imem.imem_valid;
        end else if (imem.imem_valid) begin
          load      = ~discard & (~instr_valid | consume);
          discard_n = 1'b0;
          pc_n      = load ? pc_inc : pc;
          state_n   = (discard | load) ? REQ : HOLD;
          skid_n    = (discard | load) ? skid : imem.imem_rdata;
        end
      end
      HOLD: begin
        load    = consume & ~redirect;
        state_n = consume ? REQ : HOLD;
        pc_n    = redirect ? target : (consume ? pc_inc : pc);
      end
      default: state_n = REQ;
    endcase
  end
  // the request strobe is registered: it is high for the whole cycle the FSM sits in REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= REQ;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      skid           <= '0;
      instr          <= '0;
      instr_valid    <= 1'b0;
      instr_pc       <= '0;
      ret_addr       <= '0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      discard     <= discard_n;
      skid        <= skid_n;
      instr_valid <= load | (instr_valid & ~consume);
      if (load) begin
        instr    <= load_data;
        instr_pc <= pc;
        ret_addr <= pc_inc;
      end
      imem.imem_req <= (state_n == REQ);
      if (state_n == REQ) imem.imem_addr <= pc_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table for start-up/stall/branch timing, scoreboard of consumed instructions,
// hand sequences for late-response redirect, PC wrap and asynchronous reset.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst, stall, branch_taken;
  logic [31:0] r_abs;
  logic [31:0] instr, w_instr;
  logic instr_valid, w_instr_valid;
  logic [14:0] instr_pc, ret_addr, w_instr_pc, w_ret_addr;
  int checks = 0, failures = 0;
  int lat, cnt, nreq;
  logic [14:0] pend, sb_e;
  logic [14:0] q[$];
  logic mon_en;

  instr_fetch_unit_if #(.AWIDTH(15), .DWIDTH(32)) bus ();
  instr_fetch_unit_if #(.AWIDTH(15), .DWIDTH(32)) wbus ();

  instr_fetch_unit #(.DWIDTH(32), .AWIDTH(15), .RESET_PC(15'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .r_abs(r_abs), .imem(bus),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .ret_addr(ret_addr));

  instr_fetch_unit #(.DWIDTH(32), .AWIDTH(15), .RESET_PC(15'h7FFF)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0), .r_abs(32'h0), .imem(wbus),
    .instr(w_instr), .instr_valid(w_instr_valid), .instr_pc(w_instr_pc), .ret_addr(w_ret_addr));

  always #5 clk = ~clk;

  // memory holds mem[a] = a + 0x100, answering after lat cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.imem_valid <= 1'b0;
      bus.imem_rdata <= '0;
      cnt <= 0;
      pend <= '0;
    end else begin
      bus.imem_valid <= 1'b0;
      if (bus.imem_req) begin
        pend <= bus.imem_addr;
        if (lat == 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= 32'(bus.imem_addr) + 32'h100;
        end else cnt <= lat - 1;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= 32'(pend) + 32'h100;
        end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbus.imem_valid <= 1'b0;
      wbus.imem_rdata <= '0;
    end else begin
      wbus.imem_valid <= wbus.imem_req;
      wbus.imem_rdata <= 32'(wbus.imem_addr) + 32'h100;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard: every consumed instruction must be the next expected PC
  always @(negedge clk) begin
    if (rst && mon_en && instr_valid && !stall) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        sb_e = q.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(sb_e));
        chk("sb_instr", instr, 32'(sb_e) + 32'h100);
        chk("sb_ret", 32'(ret_addr), 32'(15'(sb_e + 15'd1)));
      end
    end
  end

  typedef struct packed {
    logic stall, br, req;
    logic [14:0] addr;
    logic valid;
    logic [14:0] pc;
  } vec_t;
  vec_t tbl[20];

  initial begin
    tbl[0]  = {1'b0, 1'b0, 1'b1, 15'h00, 1'b0, 15'h00};
    tbl[1]  = {1'b0, 1'b0, 1'b0, 15'h00, 1'b0, 15'h00};
    tbl[2]  = {1'b0, 1'b0, 1'b1, 15'h01, 1'b1, 15'h00};
    tbl[3]  = {1'b0, 1'b0, 1'b0, 15'h00, 1'b0, 15'h00};
    tbl[4]  = {1'b0, 1'b0, 1'b1, 15'h02, 1'b1, 15'h01};
    tbl[5]  = {1'b0, 1'b0, 1'b0, 15'h00, 1'b0, 15'h00};
    tbl[6]  = {1'b0, 1'b0, 1'b1, 15'h03, 1'b1, 15'h02};
    tbl[7]  = {1'b1, 1'b0, 1'b0, 15'h00, 1'b1, 15'h02};
    tbl[8]  = {1'b1, 1'b0, 1'b0, 15'h00, 1'b1, 15'h02};
    tbl[9]  = {1'b1, 1'b0, 1'b0, 15'h00, 1'b1, 15'h02};
    tbl[10] = {1'b1, 1'b0, 1'b0, 15'h00, 1'b1, 15'h02};
    tbl[11] = {1'b1, 1'b0, 1'b0, 15'h00, 1'b1, 15'h02};
    tbl[12] = {1'b1, 1'b0, 1'b0, 15'h00, 1'b1, 15'h02};
    tbl[13] = {1'b0, 1'b0, 1'b1, 15'h04, 1'b1, 15'h03};
    tbl[14] = {1'b0, 1'b0, 1'b0, 15'h00, 1'b0, 15'h00};
    tbl[15] = {1'b0, 1'b0, 1'b1, 15'h05, 1'b1, 15'h04};
    tbl[16] = {1'b0, 1'b1, 1'b0, 15'h00, 1'b0, 15'h00};
    tbl[17] = {1'b0, 1'b0, 1'b1, 15'h40, 1'b0, 15'h00};
    tbl[18] = {1'b0, 1'b0, 1'b0, 15'h00, 1'b0, 15'h00};
    tbl[19] = {1'b0, 1'b0, 1'b1, 15'h41, 1'b1, 15'h40};
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; r_abs = 32'hFFFF_0040; lat = 1; mon_en = 1'b1;
    q.push_back(15'h0); q.push_back(15'h1); q.push_back(15'h2);
    q.push_back(15'h3); q.push_back(15'h4); q.push_back(15'h40);
    #3 rst = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc_ret", {1'b0, instr_pc, 1'b0, ret_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = tbl[i].stall;
      branch_taken = tbl[i].br;
      @(posedge clk); #1;
      chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
        chk($sformatf("v%0d_instr", i), instr, 32'(tbl[i].pc) + 32'h100);
        chk($sformatf("v%0d_ret", i), 32'(ret_addr), 32'(15'(tbl[i].pc + 15'd1)));
      end
      if (i == 0) chk("wrap_first_addr", 32'(wbus.imem_addr), 32'h7FFF);
      if (i == 2) begin
        chk("wrap_valid", 32'(w_instr_valid), 32'd1);
        chk("wrap_pc", 32'(w_instr_pc), 32'h7FFF);
        chk("wrap_ret", 32'(w_ret_addr), 32'h0000);
        chk("wrap_instr", w_instr, 32'h80FF);
        chk("wrap_next_req", 32'(wbus.imem_req), 32'd1);
        chk("wrap_next_addr", 32'(wbus.imem_addr), 32'h0000);
      end
    end
    branch_taken = 1'b0;
    // redirect in the same cycle the 3-cycle memory answers
    lat = 3; stall = 1'b1; r_abs = 32'h0000_1234;
    q.push_back(15'h1234);
    for (int k = 0; k < 10 && !bus.imem_valid; k++) begin @(posedge clk); #1; end
    chk("lv_resp_seen", 32'(bus.imem_valid), 32'd1);
    chk("lv_held_pc", 32'(instr_pc), 32'h40);
    stall = 1'b0; branch_taken = 1'b1;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    chk("lv_flush", 32'(instr_valid), 32'd0);
    chk("lv_req", 32'(bus.imem_req), 32'd1);
    chk("lv_target", 32'(bus.imem_addr), 32'h1234);
    nreq = 32'(bus.imem_req);
    repeat (3) begin @(posedge clk); #1; nreq += 32'(bus.imem_req); end
    chk("lv_one_req", 32'(nreq), 32'd1);
    for (int k = 0; k < 10 && !instr_valid; k++) begin @(posedge clk); #1; end
    chk("lv_valid", 32'(instr_valid), 32'd1);
    chk("lv_pc", 32'(instr_pc), 32'h1234);
    chk("lv_instr", instr, 32'h1334);
    @(posedge clk); #1;
    chk("sb_drained", 32'(q.size()), 32'd0);
    // asynchronous reset while a 3-cycle response is pending
    mon_en = 1'b0;
    chk("ar_in_wait", 32'(bus.imem_req), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("ar_req", 32'(bus.imem_req), 32'd0);
    chk("ar_addr", 32'(bus.imem_addr), 32'd0);
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_instr", instr, 32'd0);
    chk("ar_pc_ret", {1'b0, instr_pc, 1'b0, ret_addr}, 32'd0);
    repeat (2) @(negedge clk);
    lat = 1; rst = 1'b1;
    for (int k = 0; k < 10 && !bus.imem_req; k++) begin @(posedge clk); #1; end
    chk("ar_first_req", 32'(bus.imem_req), 32'd1);
    chk("ar_first_addr", 32'(bus.imem_addr), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
